// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: redirect/halt control, instruction-memory request/response
// and the decode-side valid/ready queue head.
interface instruction_fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            halt;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [31:0]     imem_resp_inst;
   logic            id_valid;
   logic            id_ready;
   logic [31:0]     id_inst;
   logic [XLEN-1:0] id_pc;
   logic            halted;

   modport master (
      input  redirect_valid, redirect_pc, halt,
      input  imem_req_ready, imem_resp_valid, imem_resp_inst,
      input  id_ready,
      output imem_req_valid, imem_req_addr,
      output id_valid, id_inst, id_pc, halted
   );

   modport slave (
      output redirect_valid, redirect_pc, halt,
      output imem_req_ready, imem_resp_valid, imem_resp_inst,
      output id_ready,
      input  imem_req_valid, imem_req_addr,
      input  id_valid, id_inst, id_pc, halted
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem request in flight and queues
// returned instructions with their PCs for decode.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_FETCH  | request may issue when the FIFO has a free slot
// ST_WAIT   | one request outstanding, waiting for its response
// ST_DRAIN  | halt seen with a request outstanding; swallow its response
// ST_HALTED | fetch permanently stopped until reset
module instruction_fetch_unit #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              BUF_DEPTH = 2
) (
   input logic                        clk,
   input logic                        reset_n,
   instruction_fetch_unit_if.master   fetch_if
);

   localparam int PTR_W = $clog2(BUF_DEPTH);

   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_HALTED = 2'd3;

   localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(4);
   localparam logic [XLEN-1:0]  ALIGN_MASK = XLEN'(3);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   DEPTH_L    = (PTR_W+1)'(BUF_DEPTH);

   logic [1:0]       r_state;
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_req_pc;
   logic             r_drop;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W:0]   r_count;
   logic [31:0]      r_fifo_inst [BUF_DEPTH];
   logic [XLEN-1:0]  r_fifo_pc   [BUF_DEPTH];

   logic             w_req_valid;
   logic             w_req_fire;
   logic             w_id_valid;
   logic             w_pop;
   logic             w_flush;
   logic             w_push;
   logic [XLEN-1:0]  w_redirect_target;

   // Requests are credit-limited by free FIFO slots, so a push never overflows.
   assign w_req_valid       = reset_n && (r_state == ST_FETCH) && (r_count < DEPTH_L);
   assign w_req_fire        = w_req_valid && fetch_if.imem_req_ready;
   assign w_id_valid        = reset_n && (r_count != '0) && (r_state != ST_HALTED);
   assign w_pop             = w_id_valid && fetch_if.id_ready;
   assign w_flush           = (fetch_if.halt || fetch_if.redirect_valid) &&
                              ((r_state == ST_FETCH) || (r_state == ST_WAIT));
   assign w_push            = (r_state == ST_WAIT) && fetch_if.imem_resp_valid &&
                              !r_drop && !w_flush;
   assign w_redirect_target = fetch_if.redirect_pc & ~ALIGN_MASK;

   assign fetch_if.imem_req_valid = w_req_valid;
   assign fetch_if.imem_req_addr  = r_pc;
   assign fetch_if.id_valid       = w_id_valid;
   assign fetch_if.id_inst        = r_fifo_inst[r_rd_ptr];
   assign fetch_if.id_pc          = r_fifo_pc[r_rd_ptr];
   assign fetch_if.halted         = reset_n && (r_state == ST_HALTED);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_inst[r_wr_ptr] <= fetch_if.imem_resp_inst;
         r_fifo_pc[r_wr_ptr]   <= r_req_pc;
      end
   end

   // Halt outranks redirect, which outranks sequential pc+4.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= ST_FETCH;
         r_pc     <= RESET_PC;
         r_req_pc <= RESET_PC;
         r_drop   <= 1'b0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (fetch_if.halt) begin
                  r_drop  <= w_req_fire;
                  r_state <= w_req_fire ? ST_DRAIN : ST_HALTED;
               end else begin
                  if (w_req_fire) begin
                     r_req_pc <= r_pc;
                     r_state  <= ST_WAIT;
                  end
                  if (fetch_if.redirect_valid) begin
                     r_pc   <= w_redirect_target;
                     r_drop <= w_req_fire;
                  end else if (w_req_fire) begin
                     r_pc <= r_pc + PC_STEP;
                  end
               end
            end
            ST_WAIT: begin
               if (fetch_if.halt) begin
                  r_drop  <= !fetch_if.imem_resp_valid;
                  r_state <= fetch_if.imem_resp_valid ? ST_HALTED : ST_DRAIN;
               end else begin
                  if (fetch_if.redirect_valid) r_pc <= w_redirect_target;
                  if (fetch_if.imem_resp_valid) begin
                     r_drop  <= 1'b0;
                     r_state <= ST_FETCH;
                  end else if (fetch_if.redirect_valid) begin
                     r_drop <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (fetch_if.imem_resp_valid) begin
                  r_drop  <= 1'b0;
                  r_state <= ST_HALTED;
               end
            end
            default: begin
               r_state <= ST_HALTED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a cycle-vector table for the
// streaming/backpressure case plus hand sequences for redirect, halt and wrap.
module tb_instruction_fetch_unit;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   instruction_fetch_unit_if #(.XLEN(32)) bus ();

   instruction_fetch_unit #(
      .XLEN      (32),
      .RESET_PC  (32'h0),
      .BUF_DEPTH (2)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .fetch_if (bus.master)
   );

   typedef struct {
      logic        ready;
      logic        id_ready;
      logic        exp_rv;
      logic [31:0] exp_addr;
      logic        exp_iv;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t        vecs [14];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          mem_lat = 1;
   int          mem_cnt = 0;
   logic        mem_pend = 1'b0;
   logic [31:0] mem_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One clock: sample the request handshake, then advance the memory model.
   task automatic tick();
      logic        fire;
      logic [31:0] a;
      @(negedge clk);
      fire = bus.imem_req_valid && bus.imem_req_ready;
      a    = bus.imem_req_addr;
      @(posedge clk);
      #1;
      bus.imem_resp_valid = 1'b0;
      if (fire) begin
         mem_pend = 1'b1;
         mem_cnt  = mem_lat;
         mem_addr = a;
      end
      if (mem_pend) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            mem_pend            = 1'b0;
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_inst  = mem_word(mem_addr);
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset_n             = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = '0;
      bus.halt            = 1'b0;
      bus.imem_req_ready  = 1'b1;
      bus.id_ready        = 1'b1;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_inst  = '0;
      mem_pend            = 1'b0;
      mem_lat             = 1;
      tick();
      tick();
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_id_valid",  32'(bus.id_valid),       32'd0);
      chk("rst_halted",    32'(bus.halted),         32'd0);
      reset_n = 1'b1;
      #1;
   endtask

   task automatic wait_req_valid(input string nm);
      for (int i = 0; i < 30 && !bus.imem_req_valid; i++) tick();
      chk({nm, "_req_timeout"}, 32'(bus.imem_req_valid), 32'd1);
   endtask

   task automatic wait_id_valid(input string nm);
      for (int i = 0; i < 30 && !bus.id_valid; i++) tick();
      chk({nm, "_id_timeout"}, 32'(bus.id_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //           rdy id_r  rv  addr          iv  pc
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h08};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10};

      // Streaming, then decode backpressure filling both FIFO slots.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         bus.imem_req_ready = vecs[i].ready;
         bus.id_ready       = vecs[i].id_ready;
         #1;
         chk($sformatf("vec%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].exp_rv));
         if (vecs[i].exp_rv)
            chk($sformatf("vec%0d_req_addr", i), bus.imem_req_addr, vecs[i].exp_addr);
         chk($sformatf("vec%0d_id_valid", i), 32'(bus.id_valid), 32'(vecs[i].exp_iv));
         if (vecs[i].exp_iv) begin
            chk($sformatf("vec%0d_id_pc", i),   bus.id_pc,   vecs[i].exp_pc);
            chk($sformatf("vec%0d_id_inst", i), bus.id_inst, mem_word(vecs[i].exp_pc));
         end
         tick();
      end

      // Redirect while the request for 0x8 is still in flight.
      do_reset();
      for (int i = 0; i < 20 && !(bus.imem_req_valid && bus.imem_req_addr == 32'h8); i++) tick();
      chk("t3_req8_addr", bus.imem_req_addr, 32'h8);
      mem_lat = 3;
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h103;
      tick();
      bus.redirect_valid = 1'b0;
      mem_lat            = 1;
      chk("t3_still_waiting", 32'(bus.imem_req_valid), 32'd0);
      chk("t3_id_empty",      32'(bus.id_valid),       32'd0);
      wait_req_valid("t3");
      chk("t3_new_addr", bus.imem_req_addr, 32'h100);
      wait_id_valid("t3");
      chk("t3_id_pc",   bus.id_pc,   32'h100);
      chk("t3_id_inst", bus.id_inst, mem_word(32'h100));

      // Redirect in the same cycle as a request handshake, FIFO non-empty.
      bus.id_ready = 1'b0;
      for (int i = 0; i < 20 && !(bus.imem_req_valid && bus.id_valid); i++) tick();
      chk("t4_pre_req", 32'(bus.imem_req_valid), 32'd1);
      chk("t4_pre_id",  32'(bus.id_valid),       32'd1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h200;
      tick();
      bus.redirect_valid = 1'b0;
      chk("t4_flushed", 32'(bus.id_valid),       32'd0);
      chk("t4_waiting", 32'(bus.imem_req_valid), 32'd0);
      bus.id_ready = 1'b1;
      wait_req_valid("t4");
      chk("t4_new_addr", bus.imem_req_addr, 32'h200);
      wait_id_valid("t4");
      chk("t4_id_pc", bus.id_pc, 32'h200);

      // Halt during WAIT drains the response then stops for good.
      wait_req_valid("t5");
      mem_lat = 3;
      tick();
      bus.halt = 1'b1;
      tick();
      bus.halt = 1'b0;
      chk("t5_draining", 32'(bus.halted),         32'd0);
      chk("t5_no_req",   32'(bus.imem_req_valid), 32'd0);
      for (int i = 0; i < 10 && !bus.halted; i++) tick();
      chk("t5_halted", 32'(bus.halted), 32'd1);
      mem_lat = 1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t5_quiet%0d", i), {30'd0, bus.imem_req_valid, bus.id_valid}, 32'd0);
         tick();
      end

      // Address held under req_ready stall, then PC wraps past 2^32.
      do_reset();
      bus.imem_req_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      tick();
      bus.redirect_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t6_hold_valid%0d", i), 32'(bus.imem_req_valid), 32'd1);
         chk($sformatf("t6_hold_addr%0d", i),  bus.imem_req_addr,       32'hFFFF_FFFC);
         tick();
      end
      bus.imem_req_ready = 1'b1;
      tick();
      wait_req_valid("t6");
      chk("t6_wrap_addr", bus.imem_req_addr, 32'h0);
      chk("t6_id_pc",     bus.id_pc,         32'hFFFF_FFFC);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
